// File: rtl/tri_raster_gen.sv
// ---------------------------------------------------------------------------
// tri_raster_gen
//   Takes the three vertices of a right triangle one per cycle and then
//   streams every integer grid point on or inside it, one point per cycle
//   with no bubbles. The right angle is at V1, V2 shares V1's y and V3
//   shares V1's x. Points are emitted row-major, walking away from V1.
//
//   Optional build macro: TRI_PTCNT_EN adds the pt_cnt point counter port.
//
// Ports
//   clk     in   clock, rising edge
//   reset   in   synchronous, active-high; clears all state
//   nt      in   new-triangle strobe, only looked at while idle
//   xi, yi  in   vertex coordinates, sampled on the three load cycles
//   hold    in   downstream stall, freezes the point stream while high
//   busy    out  high from the cycle after nt is taken until the stream ends
//   po      out  point valid; xo/yo carry a point while high
//   xo, yo  out  point coordinates (zero while no point is presented)
//   pt_cnt  out  points consumed for the current triangle (TRI_PTCNT_EN only)
// ---------------------------------------------------------------------------
module tri_raster_gen #(
    parameter int COORD_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               nt,
    input  logic [COORD_W-1:0] xi,
    input  logic [COORD_W-1:0] yi,
    input  logic               hold,
    output logic               busy,
    output logic               po,
    output logic [COORD_W-1:0] xo,
    output logic [COORD_W-1:0] yo
`ifdef TRI_PTCNT_EN
    ,
    output logic [2*COORD_W:0] pt_cnt
`endif
);

    // Membership arithmetic width: the products need 2*COORD_W+1 bits because
    // dx+1 may be one wider than a coordinate, and the sum needs one more.
    localparam int PW = 2 * COORD_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD2,
        LOAD3,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [COORD_W-1:0] x1, y1;
    logic [COORD_W-1:0] w, h;
    logic               sx, sy;
    logic [COORD_W-1:0] dx, dy;

    logic [COORD_W:0]   dx_inc;
    logic [PW-1:0]      lhs, rhs;
    logic               adv_x, adv_y;

    // A point (dx,dy) belongs to the triangle when dx*H + dy*W <= W*H. Since
    // that test only gets harder as dx grows, each row is a contiguous run
    // starting at dx=0, so looking one step ahead is enough to end a row.
    always_comb begin
        dx_inc = {1'b0, dx} + 1'b1;
        lhs    = PW'(dx_inc) * PW'(h) + PW'(dy) * PW'(w);
        rhs    = PW'(w) * PW'(h);
        adv_x  = (dx_inc <= {1'b0, w}) && (lhs <= rhs);
        adv_y  = (dy < h);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs. The stream ends on the edge that
    // consumes a point when neither dx nor dy can advance.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        po        = 1'b0;
        case (state)
            IDLE: begin
                if (nt) begin
                    state_nxt = LOAD2;
                end
            end
            LOAD2: begin
                busy      = 1'b1;
                state_nxt = LOAD3;
            end
            LOAD3: begin
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                po   = 1'b1;
                if (!hold && !adv_x && !adv_y) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Vertex capture and the dx/dy walk. W and the x direction are resolved
    // as soon as V2 arrives, H and the y direction when V3 arrives, so the
    // first point is ready the cycle after the last vertex.
    always_ff @(posedge clk) begin
        if (reset) begin
            x1 <= '0;
            y1 <= '0;
            w  <= '0;
            h  <= '0;
            sx <= 1'b0;
            sy <= 1'b0;
            dx <= '0;
            dy <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (nt) begin
                        x1 <= xi;
                        y1 <= yi;
                    end
                end
                LOAD2: begin
                    sx <= (xi >= x1);
                    w  <= (xi >= x1) ? (xi - x1) : (x1 - xi);
                end
                LOAD3: begin
                    sy <= (yi >= y1);
                    h  <= (yi >= y1) ? (yi - y1) : (y1 - yi);
                    dx <= '0;
                    dy <= '0;
                end
                RUN: begin
                    if (!hold) begin
                        if (adv_x) begin
                            dx <= dx + 1'b1;
                        end else if (adv_y) begin
                            dx <= '0;
                            dy <= dy + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Offsets are applied toward V2/V3; outside RUN the coordinates read zero.
    always_comb begin
        xo = '0;
        yo = '0;
        if (po) begin
            xo = sx ? (x1 + dx) : (x1 - dx);
            yo = sy ? (y1 + dy) : (y1 - dy);
        end
    end

`ifdef TRI_PTCNT_EN
    // Counts consumed points; restarts when a new triangle is accepted and
    // keeps its final value while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pt_cnt <= '0;
        end else if (state == IDLE && nt) begin
            pt_cnt <= '0;
        end else if (state == RUN && !hold) begin
            pt_cnt <= pt_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tri_raster_gen.sv
// ---------------------------------------------------------------------------
// tb_tri_raster_gen
//   Drives two instances of tri_raster_gen (COORD_W=3 and COORD_W=8) with
//   directed and randomized triangles and compares every presented point
//   against a list built by enumerating the triangle's grid points directly.
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_tri_raster_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic       nt3, nt8;
    logic [7:0] xi, yi;

    logic       busy3, po3, busy8, po8;
    logic [2:0] xo3, yo3;
    logic [7:0] xo8, yo8;

    logic       sel8;
    logic       obs_busy, obs_po;
    logic [7:0] obs_x, obs_y;

    int tests = 0;
    int fails = 0;

    int exp_x[$];
    int exp_y[$];

    always #5 clk = ~clk;

`ifdef TRI_PTCNT_EN
    logic [6:0]  cnt3;
    logic [16:0] cnt8;
    logic [16:0] obs_cnt;
`endif

    tri_raster_gen #(.COORD_W(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .nt    (nt3),
        .xi    (xi[2:0]),
        .yi    (yi[2:0]),
        .hold  (hold),
        .busy  (busy3),
        .po    (po3),
        .xo    (xo3),
        .yo    (yo3)
`ifdef TRI_PTCNT_EN
        ,
        .pt_cnt(cnt3)
`endif
    );

    tri_raster_gen #(.COORD_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .nt    (nt8),
        .xi    (xi),
        .yi    (yi),
        .hold  (hold),
        .busy  (busy8),
        .po    (po8),
        .xo    (xo8),
        .yo    (yo8)
`ifdef TRI_PTCNT_EN
        ,
        .pt_cnt(cnt8)
`endif
    );

    always_comb begin
        obs_busy = sel8 ? busy8 : busy3;
        obs_po   = sel8 ? po8   : po3;
        obs_x    = sel8 ? xo8   : {5'b0, xo3};
        obs_y    = sel8 ? yo8   : {5'b0, yo3};
`ifdef TRI_PTCNT_EN
        obs_cnt  = sel8 ? cnt8  : {10'b0, cnt3};
`endif
    end

    task automatic check_output(input string tag, input logic [63:0] got,
                                input logic [63:0] exp, output bit ok);
        tests++;
        ok = (got === exp);
        assert (got === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_nt(input bit v);
        nt3 = v & ~sel8;
        nt8 = v & sel8;
    endtask

    // Reference: every (dx,dy) in the bounding box with dx*H + dy*W <= W*H,
    // listed row by row from V1 outward.
    task automatic build_model(input int x1, input int y1, input int x2, input int y3);
        int w, h, sx, sy;
        exp_x.delete();
        exp_y.delete();
        w  = (x2 >= x1) ? x2 - x1 : x1 - x2;
        h  = (y3 >= y1) ? y3 - y1 : y1 - y3;
        sx = (x2 >= x1) ? 1 : -1;
        sy = (y3 >= y1) ? 1 : -1;
        for (int dy = 0; dy <= h; dy++) begin
            for (int dx = 0; dx <= w; dx++) begin
                if (dx * h + dy * w <= w * h) begin
                    exp_x.push_back(x1 + sx * dx);
                    exp_y.push_back(y1 + sy * dy);
                end
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        hold  = 1'b0;
        drive_nt(1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Loads V1=(x1,y1), V2=(x2,y1), V3=(x1,y3) into the selected instance and
    // checks the whole stream. hold_idx/hold_len force a stall on one point,
    // hold_pct adds random stalls, noise toggles nt/hold where they must be
    // ignored, abort_idx fires reset while that point is presented.
    task automatic apply_stimulus(input bit use8, input int x1, input int y1,
                                  input int x2, input int y3,
                                  input int hold_idx, input int hold_len,
                                  input int hold_pct, input bit noise,
                                  input int abort_idx);
        int  n, idx, held, cycles, budget;
        bit  ok, h;
        build_model(x1, y1, x2, y3);
        n      = exp_x.size();
        budget = 4 * n + 50;
        sel8   = use8;

        drive_nt(1'b1);
        xi   = 8'(x1);
        yi   = 8'(y1);
        hold = noise ? 1'($urandom) : 1'b0;
        @(negedge clk);
        check_output("load2_busy_po", {62'b0, obs_busy, obs_po}, 64'b10, ok);
        drive_nt(noise ? 1'($urandom) : 1'b0);
        xi   = 8'(x2);
        yi   = 8'(y1);
        hold = noise ? 1'($urandom) : 1'b0;
        @(negedge clk);
        check_output("load3_busy_po", {62'b0, obs_busy, obs_po}, 64'b10, ok);
        drive_nt(noise ? 1'($urandom) : 1'b0);
        xi   = 8'(x1);
        yi   = 8'(y3);
        hold = noise ? 1'($urandom) : 1'b0;
        @(negedge clk);

        idx    = 0;
        held   = 0;
        cycles = 0;
        ok     = 1'b1;
        while (idx < n && ok && cycles < budget) begin
            check_output("point", {46'b0, obs_busy, obs_po, obs_x, obs_y},
                         {46'b0, 1'b1, 1'b1, 8'(exp_x[idx]), 8'(exp_y[idx])}, ok);
`ifdef TRI_PTCNT_EN
            begin
                bit ok_cnt;
                check_output("pt_cnt_run", {47'b0, obs_cnt}, 64'(idx), ok_cnt);
            end
`endif
            if (idx == abort_idx) begin
                reset = 1'b1;
                hold  = 1'b0;
                drive_nt(1'b0);
                @(negedge clk);
                check_output("after_reset", {46'b0, obs_busy, obs_po, obs_x, obs_y}, 64'b0, ok);
`ifdef TRI_PTCNT_EN
                check_output("pt_cnt_reset", {47'b0, obs_cnt}, 64'b0, ok);
`endif
                reset = 1'b0;
                return;
            end
            if (idx == hold_idx && held < hold_len) begin
                h = 1'b1;
                held++;
            end else begin
                h = ($urandom_range(99) < 32'(hold_pct));
            end
            hold = h;
            drive_nt(noise ? 1'($urandom) : 1'b0);
            if (noise) begin
                xi = 8'($urandom);
                yi = 8'($urandom);
            end
            @(negedge clk);
            if (!h) idx++;
            cycles++;
        end

        if (ok && idx < n) begin
            check_output("stream_timeout", 64'(idx), 64'(n), ok);
        end
        if (!ok) begin
            pulse_reset();
            return;
        end

        check_output("end_busy_po", {62'b0, obs_busy, obs_po}, 64'b0, ok);
`ifdef TRI_PTCNT_EN
        check_output("pt_cnt_final", {47'b0, obs_cnt}, 64'(n), ok);
`endif
        hold = 1'b0;
        drive_nt(1'b0);
    endtask

    initial begin
        bit ok;
        int x1, y1, x2, y3, lo, hi, gap;

        reset = 1'b1;
        hold  = 1'b0;
        sel8  = 1'b0;
        nt3   = 1'b0;
        nt8   = 1'b0;
        xi    = '0;
        yi    = '0;
        @(negedge clk);
        @(negedge clk);
        sel8 = 1'b0;
        #1;
        check_output("reset_w3", {46'b0, obs_busy, obs_po, obs_x, obs_y}, 64'b0, ok);
        sel8 = 1'b1;
        #1;
        check_output("reset_w8", {46'b0, obs_busy, obs_po, obs_x, obs_y}, 64'b0, ok);
`ifdef TRI_PTCNT_EN
        check_output("reset_cnt", {47'b0, obs_cnt}, 64'b0, ok);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Reference triangle, mirrored orientation, single-point triangle.
        apply_stimulus(0, 1, 1, 4, 4, -1, 0, 0, 0, -1);
        apply_stimulus(0, 5, 5, 3, 2, -1, 0, 0, 0, -1);
        apply_stimulus(0, 6, 2, 6, 2, -1, 0, 0, 0, -1);

        // Three-cycle stall on (2,2), the sixth point.
        apply_stimulus(0, 1, 1, 4, 4, 5, 3, 0, 0, -1);

        // Reset while the fourth point is shown, then a fresh triangle.
        apply_stimulus(0, 1, 1, 4, 4, -1, 0, 0, 0, 3);
        apply_stimulus(0, 2, 0, 7, 5, -1, 0, 0, 0, -1);

        // Single row, single column, full-range 3-bit triangle.
        apply_stimulus(0, 0, 7, 7, 7, -1, 0, 0, 0, -1);
        apply_stimulus(0, 3, 6, 3, 0, -1, 0, 0, 0, -1);
        apply_stimulus(0, 7, 0, 0, 7, -1, 0, 20, 1, -1);

        // Largest 8-bit triangle.
        apply_stimulus(1, 0, 0, 255, 255, -1, 0, 0, 0, -1);

        // Random 3-bit triangles, sometimes back to back.
        for (int i = 0; i < 25; i++) begin
            apply_stimulus(0, $urandom_range(7), $urandom_range(7),
                           $urandom_range(7), $urandom_range(7),
                           -1, 0, 25, 1, -1);
            gap = $urandom_range(2);
            for (int g = 0; g < gap; g++) @(negedge clk);
        end

        // Random small 8-bit triangles anywhere in the coordinate space.
        for (int i = 0; i < 25; i++) begin
            x1 = $urandom_range(255);
            y1 = $urandom_range(255);
            lo = (x1 < 12) ? 0 : x1 - 12;
            hi = (x1 > 243) ? 255 : x1 + 12;
            x2 = $urandom_range(hi, lo);
            lo = (y1 < 12) ? 0 : y1 - 12;
            hi = (y1 > 243) ? 255 : y1 + 12;
            y3 = $urandom_range(hi, lo);
            apply_stimulus(1, x1, y1, x2, y3, -1, 0, 25, 1, -1);
            gap = $urandom_range(2);
            for (int g = 0; g < gap; g++) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tri_raster_gen.md
Name: tri_raster_gen

Overview:
- Parametrised successor of the Lab00 right-triangle point generator.
- Accepts three vertices serially, one per cycle, after an `nt` start pulse, then streams every integer grid point on or inside the triangle, one point per cycle with no bubbles.
- New over the previous generation: configurable coordinate width, all four right-angle orientations, an output `hold` stall and defined degenerate-triangle handling.
- Sits between the vertex source and the pixel-write/scoreboard stage of the lab datapath.

Parameters:
COORD_W, 3, bit width of every x/y coordinate (legal 2..10)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
nt  in  1  new-triangle strobe; sampled only in IDLE
xi  in  COORD_W  vertex x, sampled on load cycles
yi  in  COORD_W  vertex y, sampled on load cycles
hold  in  1  downstream stall; freezes output stream while high
busy  out  1  high from cycle after nt sample until stream ends
po  out  1  point-valid; xo/yo carry a point when high
xo  out  COORD_W  point x
yo  out  COORD_W  point y
pt_cnt  out  2*COORD_W+1  points emitted for current triangle (only with TRI_PTCNT_EN)

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. Reset values: busy=0, po=0, xo=0, yo=0, pt_cnt=0. State goes to IDLE at the next edge, including mid-load or mid-stream; any partial triangle is discarded.
- States: IDLE, LOAD2, LOAD3, RUN.
- IDLE:
  - If nt=1, capture V1=(xi,yi) and go to LOAD2.
  - nt is ignored in every other state.
- LOAD2: capture V2=(xi,yi), go to LOAD3.
- LOAD3: capture V3=(xi,yi), compute the deltas below, go to RUN.
- Vertex convention: right angle at V1, with y2==y1 and x3==x1. Inputs violating this give undefined output but must not hang.
- Deltas:
  - W=|x2-x1|, H=|y3-y1|, both COORD_W bits.
  - sx=+1 if x2>=x1 else -1; sy=+1 if y3>=y1 else -1.
- Membership of (dx,dy), for 0<=dx<=W and 0<=dy<=H: dx*H + dy*W <= W*H.
  - Products are 2*COORD_W bits; the sum is 2*COORD_W+1 bits with no truncation.
- Emission order:
  - Row-major from dy=0 to dy=H; within a row, dx from 0 upward.
  - Emitted point: xo = x1+sx*dx, yo = y1+sy*dy.
- Next-point logic (combinational, evaluated in RUN when hold=0):
  - If dx+1<=W and (dx+1) satisfies membership, advance dx.
  - Else, if dy<H, set dx=0 and advance dy. (dx=0 is always a member.)
  - Else the current point is the last one.
- Timing, with nt sampled at edge T:
  - busy=1 from T+1.
  - First point: po=1 with (x1,y1) during the cycle after the LOAD3 edge, i.e. T+3.
- Stream: po stays 1 every RUN cycle.
  - A point counts as consumed on an edge with po=1 and hold=0.
- hold=1 in RUN: dx, dy, xo, yo and po are frozen; po remains 1; busy remains 1.
- hold in other states: no effect.
- End of stream: on the edge that consumes the last point, go to IDLE; po=0 and busy=0 the following cycle. nt may be asserted in that same cycle.
- Total RUN cycles equal the point count plus the number of hold cycles.
- Degenerate triangles:
  - H=0: one row, W+1 points.
  - W=0: one column, H+1 points.
  - W=H=0: a single point (x1,y1), with po high for exactly one cycle when hold=0.
- No wrap-around: all emitted coordinates lie between the vertex extremes.

Optional Feature:
- Macro TRI_PTCNT_EN.
- When defined:
  - Port pt_cnt exists.
  - pt_cnt clears to 0 on the nt capture and increments on each consumed point.
  - pt_cnt holds its final value in IDLE until the next nt or reset.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- COORD_W=3, V1=(1,1), V2=(4,1), V3=(1,4), hold=0 -> exactly 10 points, in order (1,1),(2,1),(3,1),(4,1),(1,2),(2,2),(3,2),(1,3),(2,3),(1,4); first po at T+3; busy falls the cycle after (1,4); pt_cnt=10.
- Mirrored orientation: V1=(5,5), V2=(3,5), V3=(5,2) -> 7 points: (5,5),(4,5),(3,5),(5,4),(4,4),(5,3),(5,2).
- Degenerate: V1=V2=V3=(6,2) -> a single po pulse with (6,2); busy high for exactly 3 cycles.
- Stall: first test with hold=1 for 3 cycles while (2,2) is presented -> xo/yo stay (2,2) and po=1 through the stall; sequence otherwise unchanged; pt_cnt=10.
- Reset at the 4th point of the first test -> next cycle busy=0, po=0, xo=yo=0; a new nt is then accepted and streams correctly from its own V1.
- COORD_W=8, V1=(0,0), V2=(255,0), V3=(0,255) -> no product overflow; last point (0,255); point count equals the reference-model count.
